pipe_hazard_ctrl: RTL and testbench

Central stall, flush and freeze sequencer for the 5-stage processor pipeline. It detects load-use hazards between the ID/EX register and the instruction in ID, and squashes wrong-path fetches after a taken branch or jump resolved in ID. It freezes the whole pipe while a data-memory access is outstanding, and drives the load/bubble controls of the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers. It also keeps saturating stall and flush statistics.

---
 rtl/pipe_hazard_ctrl_pkg.sv | 31 +++
 rtl/pipe_hazard_ctrl_if.sv | 40 ++++
 rtl/pipe_hazard_ctrl_lu_detect.sv | 21 ++
 rtl/pipe_hazard_ctrl.sv | 144 ++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 172 +++++++++++++++++
 5 files changed

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard sequencer.
// Control bundle ordering matches the pipeline register order PC -> MEM/WB.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        FLUSH    = 2'd2
    } state_t;

    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic pc_ld;
        logic ifid_ld;
        logic ifid_flush;
        logic idex_ld;
        logic idex_bubble;
        logic exmem_ld;
        logic memwb_bubble;
    } ctrl_t;

    localparam ctrl_t CTRL_DEFAULT = '{pc_ld: 1'b1, ifid_ld: 1'b1, ifid_flush: 1'b0,
                                       idex_ld: 1'b1, idex_bubble: 1'b0,
                                       exmem_ld: 1'b1, memwb_bubble: 1'b0};

    localparam ctrl_t CTRL_FREEZE  = '{pc_ld: 1'b0, ifid_ld: 1'b0, ifid_flush: 1'b0,
                                       idex_ld: 1'b0, idex_bubble: 1'b0,
                                       exmem_ld: 1'b0, memwb_bubble: 1'b1};

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard inputs from the pipeline and the register-control/statistics outputs back to it.
// master = pipeline side, slave = hazard sequencer.
interface pipe_hazard_ctrl_if #(
    parameter int CNT_W = 16
);
    logic [4:0]       id_rs;
    logic [4:0]       id_rt;
    logic             id_uses_rt;
    logic             idex_mem_read;
    logic [4:0]       idex_rt;
    logic             br_taken;
    logic             mem_req;
    logic             mem_ready;

    logic             pc_ld;
    logic             ifid_ld;
    logic             ifid_flush;
    logic             idex_ld;
    logic             idex_bubble;
    logic             exmem_ld;
    logic             memwb_bubble;
    logic             mem_err;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    modport master (
        output id_rs, id_rt, id_uses_rt, idex_mem_read, idex_rt,
               br_taken, mem_req, mem_ready,
        input  pc_ld, ifid_ld, ifid_flush, idex_ld, idex_bubble,
               exmem_ld, memwb_bubble, mem_err, stall_cnt, flush_cnt
    );

    modport slave (
        input  id_rs, id_rt, id_uses_rt, idex_mem_read, idex_rt,
               br_taken, mem_req, mem_ready,
        output pc_ld, ifid_ld, ifid_flush, idex_ld, idex_bubble,
               exmem_ld, memwb_bubble, mem_err, stall_cnt, flush_cnt
    );

endinterface

// File: rtl/pipe_hazard_ctrl_lu_detect.sv
// Load-use compare between the load in ID/EX and the source registers of the ID instruction.
// Purely combinational, zero latency; r0 is never a real dependence.
module lu_detect
    import pipe_ctrl_pkg::*;
(
    input  logic       i_idex_mem_read,
    input  logic [4:0] i_idex_rt,
    input  logic [4:0] i_id_rs,
    input  logic [4:0] i_id_rt,
    input  logic       i_id_uses_rt,
    output logic       o_lu
);

    logic w_rs_hit;
    logic w_rt_hit;

    assign w_rs_hit = (i_idex_rt == i_id_rs);
    assign w_rt_hit = i_id_uses_rt && (i_idex_rt == i_id_rt);
    assign o_lu     = i_idex_mem_read && (i_idex_rt != REG_ZERO) && (w_rs_hit || w_rt_hit);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush/freeze sequencer for the 5-stage pipe; Mealy controls, same-cycle response.
// Memory freeze holds every stage until mem_ready or the wait timeout releases it.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int BR_PENALTY  = 1,
    parameter int MEM_TIMEOUT = 64,
    parameter int CNT_W       = 16
) (
    input  logic                clk,
    input  logic                rst,
    pipe_hazard_ctrl_if.slave   bus
);

    localparam int              WAIT_W    = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);
    localparam logic [1:0]      FL_LOAD   = 2'(BR_PENALTY - 1);

    state_t            r_state;
    logic [1:0]        r_fl_cnt;
    logic [WAIT_W-1:0] r_wait_cnt;
    logic              r_mem_err;
    logic [CNT_W-1:0]  r_stall_cnt;
    logic [CNT_W-1:0]  r_flush_cnt;

    logic  w_lu;
    logic  w_freeze;
    logic  w_timeout;
    logic  w_br_acc;
    ctrl_t w_ctrl;

    lu_detect u_lu_detect (
        .i_idex_mem_read (bus.idex_mem_read),
        .i_idex_rt       (bus.idex_rt),
        .i_id_rs         (bus.id_rs),
        .i_id_rt         (bus.id_rt),
        .i_id_uses_rt    (bus.id_uses_rt),
        .o_lu            (w_lu)
    );

    assign w_freeze  = bus.mem_req && !bus.mem_ready;
    assign w_timeout = (r_state == MEM_WAIT) && !bus.mem_ready && (r_wait_cnt == WAIT_LAST);

    // Priority within RUN: freeze, then load-use, then taken branch.
    always_comb begin
        w_ctrl   = CTRL_DEFAULT;
        w_br_acc = 1'b0;
        if (rst) begin
            case (r_state)
                RUN: begin
                    if (w_freeze) begin
                        w_ctrl = CTRL_FREEZE;
                    end else if (w_lu) begin
                        w_ctrl.pc_ld       = 1'b0;
                        w_ctrl.ifid_ld     = 1'b0;
                        w_ctrl.idex_bubble = 1'b1;
                    end else if (bus.br_taken) begin
                        w_ctrl.ifid_flush = 1'b1;
                        w_br_acc          = 1'b1;
                    end
                end
                FLUSH: begin
                    if (w_freeze) begin
                        w_ctrl = CTRL_FREEZE;
                    end else begin
                        w_ctrl.ifid_flush = 1'b1;
                    end
                end
                MEM_WAIT: begin
                    if (!bus.mem_ready && !w_timeout) begin
                        w_ctrl = CTRL_FREEZE;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= RUN;
            r_fl_cnt    <= 2'd0;
            r_wait_cnt  <= '0;
            r_mem_err   <= 1'b0;
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            case (r_state)
                RUN: begin
                    if (w_freeze) begin
                        r_state    <= MEM_WAIT;
                        r_wait_cnt <= '0;
                    end else if (w_br_acc && (BR_PENALTY > 1)) begin
                        r_state  <= FLUSH;
                        r_fl_cnt <= FL_LOAD;
                    end
                end
                FLUSH: begin
                    // An interrupted flush is dropped, not resumed after the freeze.
                    if (w_freeze) begin
                        r_state    <= MEM_WAIT;
                        r_wait_cnt <= '0;
                        r_fl_cnt   <= 2'd0;
                    end else begin
                        r_fl_cnt <= r_fl_cnt - 2'd1;
                        if (r_fl_cnt == 2'd1) begin
                            r_state <= RUN;
                        end
                    end
                end
                MEM_WAIT: begin
                    if (bus.mem_ready) begin
                        r_state <= RUN;
                    end else if (w_timeout) begin
                        r_state   <= RUN;
                        r_mem_err <= 1'b1;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 1'b1;
                    end
                end
                default: r_state <= RUN;
            endcase

            if (!w_ctrl.pc_ld && (r_stall_cnt != {CNT_W{1'b1}})) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
            if (w_br_acc && (r_flush_cnt != {CNT_W{1'b1}})) begin
                r_flush_cnt <= r_flush_cnt + 1'b1;
            end
        end
    end

    assign bus.pc_ld        = w_ctrl.pc_ld;
    assign bus.ifid_ld      = w_ctrl.ifid_ld;
    assign bus.ifid_flush   = w_ctrl.ifid_flush;
    assign bus.idex_ld      = w_ctrl.idex_ld;
    assign bus.idex_bubble  = w_ctrl.idex_bubble;
    assign bus.exmem_ld     = w_ctrl.exmem_ld;
    assign bus.memwb_bubble = w_ctrl.memwb_bubble;
    assign bus.mem_err      = r_mem_err;
    assign bus.stall_cnt    = r_stall_cnt;
    assign bus.flush_cnt    = r_flush_cnt;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl with BR_PENALTY=2, MEM_TIMEOUT=4.
// Control vector order: {pc_ld, ifid_ld, ifid_flush, idex_ld, idex_bubble, exmem_ld, memwb_bubble}.
module tb_pipe_hazard_ctrl;
    import pipe_ctrl_pkg::*;

    localparam logic [6:0] DEF = 7'b1101010;
    localparam logic [6:0] FRZ = 7'b0000001;
    localparam logic [6:0] STL = 7'b0001110;
    localparam logic [6:0] FLS = 7'b1111010;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;

    pipe_hazard_ctrl_if #(.CNT_W(16)) bus ();

    pipe_hazard_ctrl #(
        .BR_PENALTY  (2),
        .MEM_TIMEOUT (4),
        .CNT_W       (16)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    logic [6:0] ctrl_obs;
    assign ctrl_obs = {bus.pc_ld, bus.ifid_ld, bus.ifid_flush, bus.idex_ld,
                       bus.idex_bubble, bus.exmem_ld, bus.memwb_bubble};

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        assert (act === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, act, exp);
        end
    endtask

    task automatic idle();
        bus.id_rs         = 5'd1;
        bus.id_rt         = 5'd2;
        bus.id_uses_rt    = 1'b0;
        bus.idex_mem_read = 1'b0;
        bus.idex_rt       = 5'd0;
        bus.br_taken      = 1'b0;
        bus.mem_req       = 1'b0;
        bus.mem_ready     = 1'b0;
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        idle();
        #1 rst = 1'b0;
        bus.idex_mem_read = 1'b1; bus.idex_rt = 5'd5; bus.id_rs = 5'd5;
        bus.br_taken = 1'b1; bus.mem_req = 1'b1;
        #1;
        chk("rst_ctrl", 32'(ctrl_obs), 32'(DEF));
        chk("rst_stall", 32'(bus.stall_cnt), 32'd0);
        chk("rst_flush", 32'(bus.flush_cnt), 32'd0);
        chk("rst_err", 32'(bus.mem_err), 32'd0);
        @(negedge clk);
        idle();
        rst = 1'b1;

        // load-use on Rs
        nxt(); bus.idex_mem_read = 1'b1; bus.idex_rt = 5'd5; bus.id_rs = 5'd5; #1;
        chk("lu_stall", 32'(ctrl_obs), 32'(STL));
        nxt(); idle(); #1;
        chk("lu_one_cycle", 32'(ctrl_obs), 32'(DEF));
        chk("lu_stall_cnt", 32'(bus.stall_cnt), 32'd1);
        nxt(); bus.idex_mem_read = 1'b1; bus.idex_rt = 5'd0; bus.id_rs = 5'd0; #1;
        chk("lu_r0", 32'(ctrl_obs), 32'(DEF));

        // Rt dependence, with and without id_uses_rt
        nxt(); bus.idex_mem_read = 1'b1; bus.idex_rt = 5'd7; bus.id_rt = 5'd7; bus.id_rs = 5'd1; #1;
        chk("rt_unused", 32'(ctrl_obs), 32'(DEF));
        nxt(); bus.id_uses_rt = 1'b1; #1;
        chk("rt_used", 32'(ctrl_obs), 32'(STL));
        nxt(); idle(); #1;
        chk("rt_release", 32'(ctrl_obs), 32'(DEF));
        chk("rt_stall_cnt", 32'(bus.stall_cnt), 32'd2);

        // taken branch, penalty 2
        nxt(); bus.br_taken = 1'b1; #1;
        chk("br_c0", 32'(ctrl_obs), 32'(FLS));
        nxt(); bus.br_taken = 1'b0; #1;
        chk("br_c1", 32'(ctrl_obs), 32'(FLS));
        chk("br_flush_cnt", 32'(bus.flush_cnt), 32'd1);
        nxt(); #1;
        chk("br_done", 32'(ctrl_obs), 32'(DEF));
        chk("br_state", 32'(dut.r_state), 32'(RUN));

        // memory freeze, 3 cycles then ready
        nxt(); bus.mem_req = 1'b1; bus.mem_ready = 1'b0; #1;
        chk("frz_c0", 32'(ctrl_obs), 32'(FRZ));
        nxt(); #1;
        chk("frz_c1", 32'(ctrl_obs), 32'(FRZ));
        nxt(); #1;
        chk("frz_c2", 32'(ctrl_obs), 32'(FRZ));
        nxt(); bus.mem_ready = 1'b1; #1;
        chk("frz_release", 32'(ctrl_obs), 32'(DEF));
        chk("frz_stall_cnt", 32'(bus.stall_cnt), 32'd5);
        nxt(); #1;
        chk("req_rdy_run", 32'(ctrl_obs), 32'(DEF));
        nxt(); idle(); #1;
        chk("req_rdy_state", 32'(dut.r_state), 32'(RUN));
        chk("req_rdy_stall", 32'(bus.stall_cnt), 32'd5);

        // timeout: MEM_TIMEOUT=4 wait cycles
        nxt(); bus.mem_req = 1'b1; bus.mem_ready = 1'b0; #1;
        chk("to_run_frz", 32'(ctrl_obs), 32'(FRZ));
        nxt(); #1; chk("to_w0", 32'(ctrl_obs), 32'(FRZ));
        nxt(); #1; chk("to_w1", 32'(ctrl_obs), 32'(FRZ));
        nxt(); #1; chk("to_w2", 32'(ctrl_obs), 32'(FRZ));
        nxt(); #1;
        chk("to_release", 32'(ctrl_obs), 32'(DEF));
        chk("to_err_pending", 32'(bus.mem_err), 32'd0);
        nxt(); #1;
        chk("to_err", 32'(bus.mem_err), 32'd1);
        chk("to_state", 32'(dut.r_state), 32'(RUN));
        chk("to_stall_cnt", 32'(bus.stall_cnt), 32'd9);
        chk("to_refreeze", 32'(ctrl_obs), 32'(FRZ));
        nxt(); #1;
        chk("to_rewait", 32'(dut.r_state), 32'(MEM_WAIT));

        // reset in the middle of a wait
        rst = 1'b0; #1;
        chk("mrst_ctrl", 32'(ctrl_obs), 32'(DEF));
        chk("mrst_state", 32'(dut.r_state), 32'(RUN));
        chk("mrst_err", 32'(bus.mem_err), 32'd0);
        chk("mrst_stall", 32'(bus.stall_cnt), 32'd0);
        chk("mrst_flush", 32'(bus.flush_cnt), 32'd0);
        chk("mrst_wait", 32'(dut.r_wait_cnt), 32'd0);
        idle(); #1;
        rst = 1'b1;

        // priority: freeze > load-use > branch
        nxt();
        bus.idex_mem_read = 1'b1; bus.idex_rt = 5'd5; bus.id_rs = 5'd5;
        bus.br_taken = 1'b1; bus.mem_req = 1'b1; bus.mem_ready = 1'b0; #1;
        chk("pri_frz", 32'(ctrl_obs), 32'(FRZ));
        nxt(); bus.mem_ready = 1'b1; #1;
        chk("pri_release", 32'(ctrl_obs), 32'(DEF));
        nxt(); bus.mem_req = 1'b0; bus.mem_ready = 1'b0; #1;
        chk("pri_lu", 32'(ctrl_obs), 32'(STL));
        nxt(); bus.idex_mem_read = 1'b0; #1;
        chk("pri_br0", 32'(ctrl_obs), 32'(FLS));
        nxt(); #1;
        chk("pri_br1_ignores_br", 32'(ctrl_obs), 32'(FLS));
        nxt(); bus.br_taken = 1'b0; #1;
        chk("pri_done", 32'(ctrl_obs), 32'(DEF));
        chk("pri_flush_cnt", 32'(bus.flush_cnt), 32'd1);
        chk("pri_stall_cnt", 32'(bus.stall_cnt), 32'd2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
